// File: rtl/usrt_tx_if.sv
// rtl/usrt_tx_if.sv - request handshake and serial line of the USRT transmitter
interface usrt_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       tx_done;
  logic       usrt_tx;
  logic       usrt_clk;

  modport master (
    output tx_data, tx_start,
    input  busy, tx_done, usrt_tx, usrt_clk
  );

  modport slave (
    input  tx_data, tx_start,
    output busy, tx_done, usrt_tx, usrt_clk
  );
endinterface

// File: rtl/usrt_tx.sv
// rtl/usrt_tx.sv - USRT transmitter: start/8 data LSB first/stop framing with a free-running usrt_clk
module usrt_tx #(
  parameter int HALF_DIV = 16
) (
  input  logic     clk,
  input  logic     rst,
  usrt_tx_if.slave bus
);
  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [9:0]       shreg, shreg_nxt;
  logic             line, line_nxt;
  logic             done, done_nxt;
  logic             sclk;
  logic             div_term;
  logic             rise_evt;

  assign div_term = (div_cnt == DIV_LAST);
  assign rise_evt = div_term && !sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (div_term) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      line    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      line    <= line_nxt;
      done    <= done_nxt;
    end
  end

  // Line updates coincide with the usrt_clk rise so the far end samples mid-bit on the fall.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    line_nxt    = line;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        line_nxt = 1'b1;
        if (bus.tx_start) begin
          shreg_nxt   = {1'b1, bus.tx_data, 1'b0};
          bit_cnt_nxt = '0;
          state_nxt   = ARMED;
        end
      end
      ARMED: begin
        if (rise_evt) begin
          line_nxt  = shreg[0];
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (rise_evt) begin
          if (bit_cnt < 4'd9) begin
            shreg_nxt   = {1'b1, shreg[9:1]};
            line_nxt    = shreg[1];
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else begin
            line_nxt  = 1'b1;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.tx_done  = done;
  assign bus.usrt_tx  = line;
  assign bus.usrt_clk = sclk;
endmodule

// File: tb/tb_usrt_tx.sv
// tb/tb_usrt_tx.sv - self-checking bench for usrt_tx with a behavioural falling-edge USRT receiver
module tb_usrt_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  usrt_tx_if if4 ();
  usrt_tx_if if2 ();

  usrt_tx #(.HALF_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  usrt_tx #(.HALF_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int n_checks = 0;
  int n_fail   = 0;
  int done_n4 = 0, done_n2 = 0, busy_n4 = 0, rx_n4 = 0, rx_n2 = 0;
  int r4_pos = -1, r2_pos = -1;
  logic [7:0] r4_byte = '0, r2_byte = '0;
  logic [7:0] rx_q4[$], rx_q2[$];
  logic fall_q4[$], fall_q2[$];

  // Receiver: idle until a 0 is sampled, then 8 data bits LSB first, then a stop bit of 1.
  always @(negedge if4.usrt_clk or negedge rst) begin
    if (!rst) r4_pos = -1;
    else begin
      fall_q4.push_back(if4.usrt_tx);
      if (r4_pos < 0) begin
        if (!if4.usrt_tx) r4_pos = 0;
      end else if (r4_pos < 8) begin
        r4_byte = {if4.usrt_tx, r4_byte[7:1]};
        r4_pos++;
      end else begin
        if (if4.usrt_tx) begin rx_q4.push_back(r4_byte); rx_n4++; end
        r4_pos = -1;
      end
    end
  end

  always @(negedge if2.usrt_clk or negedge rst) begin
    if (!rst) r2_pos = -1;
    else begin
      fall_q2.push_back(if2.usrt_tx);
      if (r2_pos < 0) begin
        if (!if2.usrt_tx) r2_pos = 0;
      end else if (r2_pos < 8) begin
        r2_byte = {if2.usrt_tx, r2_byte[7:1]};
        r2_pos++;
      end else begin
        if (if2.usrt_tx) begin rx_q2.push_back(r2_byte); rx_n2++; end
        r2_pos = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (if4.tx_done) done_n4++;
    if (if2.tx_done) done_n2++;
    if (if4.busy) busy_n4++;
  end

  function automatic logic busy_of(input int sel);
    return (sel == 4) ? if4.busy : if2.busy;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 4) ? if4.tx_done : if2.tx_done;
  endfunction

  function automatic logic line_of(input int sel);
    return (sel == 4) ? if4.usrt_tx : if2.usrt_tx;
  endfunction

  function automatic logic sclk_of(input int sel);
    return (sel == 4) ? if4.usrt_clk : if2.usrt_clk;
  endfunction

  task automatic drive(input int sel, input logic start, input logic [7:0] d);
    if (sel == 4) begin if4.tx_start = start; if4.tx_data = d; end
    else begin if2.tx_start = start; if2.tx_data = d; end
  endtask

  task automatic start_tx(input int sel, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (busy_of(sel) && n < 1000) begin @(negedge clk); n++; end
    n_checks++;
    if (busy_of(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL start_tx_idle: busy=%b after %0d cycles, required 0", busy_of(sel), n);
    end
    drive(sel, 1'b1, d);
    @(negedge clk);
    drive(sel, 1'b0, d);
  endtask

  task automatic wait_done(input int sel);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done_of(sel) && n < 1000);
    n_checks++;
    if (done_of(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done: tx_done=%b after %0d cycles, required 1", done_of(sel), n);
    end
  endtask

  task automatic wait_start_bit(input int sel);
    int n = 0;
    while (line_of(sel) !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (line_of(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL start_bit: usrt_tx=%b after %0d cycles, required 0", line_of(sel), n);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int s = 2; s <= 4; s += 2) begin
      n_checks++;
      if ({line_of(s), sclk_of(s), busy_of(s), done_of(s)} !== 4'b1000) begin
        n_fail++;
        $display("FAIL %s hd%0d: tx/clk/busy/done=%b, required 1000", tag, s,
                 {line_of(s), sclk_of(s), busy_of(s), done_of(s)});
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset;
    int n = 0;
    start_tx(4, 8'h00);
    while (!(if4.usrt_clk === 1'b1 && if4.usrt_tx === 1'b0 && if4.busy === 1'b1) && n < 200) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (n >= 200) begin n_fail++; $display("FAIL async_setup: mid-frame point not reached, got n=%0d required <200", n); end
    #2 rst = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_frame_bits;
    logic exp_bits[$];
    logic [7:0] d = 8'hA5;
    int b0, d0, s;
    rx_q4.delete();
    fall_q4.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(1'b1);
    b0 = busy_n4; d0 = done_n4;
    start_tx(4, d);
    wait_done(4);
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy_n4 - b0 < 81 || busy_n4 - b0 > 88) begin
      n_fail++; $display("FAIL busy_len: %0d cycles, required 81..88", busy_n4 - b0);
    end
    n_checks++;
    if (done_n4 - d0 != 1) begin n_fail++; $display("FAIL done_pulses: %0d, required 1", done_n4 - d0); end
    s = -1;
    for (int i = 0; i < fall_q4.size(); i++) if (s < 0 && fall_q4[i] == 1'b0) s = i;
    n_checks++;
    if (s < 0 || s + 10 > fall_q4.size()) begin
      n_fail++; $display("FAIL fall_count: start=%0d size=%0d, required 10 samples", s, fall_q4.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (fall_q4[s+i] !== exp_bits[i]) begin
          n_fail++; $display("FAIL fall_bit%0d: got %b, required %b", i, fall_q4[s+i], exp_bits[i]);
        end
      end
    end
    n_checks++;
    if (rx_q4.size() != 1 || rx_q4[0] !== d) begin
      n_fail++; $display("FAIL rx_a5: got %0d bytes first %h, required 1 byte a5", rx_q4.size(),
                         (rx_q4.size() > 0) ? rx_q4[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
    logic exp_bits[$];
    int n0, d0, s;
    rx_q2.delete();
    fall_q2.delete();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) exp_bits.push_back(1'b1);
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(bytes[k][i]);
      exp_bits.push_back(1'b1);
    end
    n0 = rx_n2; d0 = done_n2;
    start_tx(2, bytes[0]);
    for (int k = 1; k < 3; k++) begin
      wait_done(2);
      n_checks++;
      if (if2.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: busy=%b in done cycle, required 0", if2.busy); end
      drive(2, 1'b1, bytes[k]);
      @(negedge clk);
      drive(2, 1'b0, bytes[k]);
    end
    wait_done(2);
    repeat (12) @(negedge clk);
    n_checks++;
    if (rx_n2 - n0 != 3) begin n_fail++; $display("FAIL b2b_rdy: %0d, required 3", rx_n2 - n0); end
    n_checks++;
    if (done_n2 - d0 != 3) begin n_fail++; $display("FAIL b2b_done: %0d, required 3", done_n2 - d0); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rx_q2.size() <= k || rx_q2[k] !== bytes[k]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h, required %h", k, (rx_q2.size() > k) ? rx_q2[k] : 8'hxx, bytes[k]);
      end
    end
    s = -1;
    for (int i = 0; i < fall_q2.size(); i++) if (s < 0 && fall_q2[i] == 1'b0) s = i;
    n_checks++;
    if (s < 0 || s + 32 > fall_q2.size()) begin
      n_fail++; $display("FAIL b2b_stream_len: start=%0d size=%0d, required 32 samples", s, fall_q2.size());
    end else begin
      int bad = 0;
      for (int i = 0; i < 32; i++) if (fall_q2[s+i] !== exp_bits[i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL b2b_stream: %0d wrong samples, required 0", bad); end
    end
  endtask

  task automatic test_ignore_busy_start;
    int n0, d0;
    rx_q4.delete();
    n0 = rx_n4; d0 = done_n4;
    start_tx(4, 8'hA5);
    wait_start_bit(4);
    repeat (35) @(negedge clk);
    n_checks++;
    if (if4.busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: busy=%b mid-frame, required 1", if4.busy); end
    drive(4, 1'b1, 8'h55);
    @(negedge clk);
    drive(4, 1'b0, 8'($urandom));
    wait_done(4);
    repeat (240) @(negedge clk);
    n_checks++;
    if (rx_n4 - n0 != 1 || rx_q4.size() != 1 || rx_q4[0] !== 8'hA5) begin
      n_fail++; $display("FAIL ignore_rx: %0d bytes first %h, required 1 byte a5", rx_n4 - n0,
                         (rx_q4.size() > 0) ? rx_q4[0] : 8'hxx);
    end
    n_checks++;
    if (done_n4 - d0 != 1) begin n_fail++; $display("FAIL ignore_done: %0d, required 1", done_n4 - d0); end
  endtask

  task automatic test_idle;
    for (int sel = 2; sel <= 4; sel += 2) begin
      int n0 = rx_n4 + rx_n2;
      int bad_tx = 0, bad_run = 0, toggles = 0, run = 0;
      logic prev;
      @(negedge clk);
      prev = sclk_of(sel);
      for (int c = 0; c < 100 * sel; c++) begin
        @(negedge clk);
        if (line_of(sel) !== 1'b1) bad_tx++;
        if (sclk_of(sel) !== prev) begin
          if (toggles > 0 && run != sel) bad_run++;
          toggles++; run = 1; prev = sclk_of(sel);
        end else run++;
      end
      n_checks++;
      if (bad_tx != 0) begin n_fail++; $display("FAIL idle_line hd%0d: %0d non-1 samples, required 0", sel, bad_tx); end
      n_checks++;
      if (bad_run != 0 || toggles < 99) begin
        n_fail++; $display("FAIL idle_clk hd%0d: %0d bad halves %0d toggles, required 0 and >=99", sel, bad_run, toggles);
      end
      n_checks++;
      if (rx_n4 + rx_n2 != n0) begin n_fail++; $display("FAIL idle_rdy hd%0d: %0d, required 0", sel, rx_n4 + rx_n2 - n0); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int n0, d0;
    rx_q4.delete();
    n0 = rx_n4; d0 = done_n4;
    start_tx(4, 8'h81);
    wait_start_bit(4);
    repeat (43) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_n4 != d0 || rx_n4 != n0) begin
      n_fail++; $display("FAIL abort: done+%0d rdy+%0d, required 0 and 0", done_n4 - d0, rx_n4 - n0);
    end
    start_tx(4, 8'h81);
    wait_done(4);
    @(negedge clk);
    n_checks++;
    if (rx_q4.size() != 1 || rx_q4[0] !== 8'h81 || done_n4 - d0 != 1) begin
      n_fail++; $display("FAIL after_abort: %0d bytes first %h done+%0d, required 1 byte 81 done+1", rx_q4.size(),
                         (rx_q4.size() > 0) ? rx_q4[0] : 8'hxx, done_n4 - d0);
    end
  endtask

  task automatic test_random;
    for (int sel = 2; sel <= 4; sel += 2) begin
      logic [7:0] exp_q[$];
      int d0 = (sel == 4) ? done_n4 : done_n2;
      rx_q4.delete();
      rx_q2.delete();
      for (int k = 0; k < 6; k++) begin
        logic [7:0] d = 8'($urandom);
        exp_q.push_back(d);
        start_tx(sel, d);
        wait_done(sel);
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      for (int k = 0; k < 6; k++) begin
        logic [7:0] got = (sel == 4) ? ((rx_q4.size() > k) ? rx_q4[k] : 8'hxx)
                                     : ((rx_q2.size() > k) ? rx_q2[k] : 8'hxx);
        n_checks++;
        if (got !== exp_q[k]) begin n_fail++; $display("FAIL rand hd%0d byte%0d: got %h, required %h", sel, k, got, exp_q[k]); end
      end
      n_checks++;
      if (((sel == 4) ? done_n4 : done_n2) - d0 != 6) begin
        n_fail++; $display("FAIL rand hd%0d done: %0d, required 6", sel, ((sel == 4) ? done_n4 : done_n2) - d0);
      end
    end
  endtask

  initial begin
    drive(4, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    test_reset();
    test_async_reset();
    test_frame_bits();
    test_back_to_back();
    test_ignore_busy_start();
    test_idle();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
